// File: rtl/apb_master.sv
// APB requester: turns one valid/ready command into one APB transfer and
// returns the result on a valid/ready response port, with a wait-state watchdog.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              p_clk,
  input  logic              p_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] p_add,
  output logic              p_sel,
  output logic              p_enable,
  output logic              p_write,
  output logic [DATA_W-1:0] p_wdata,
  input  logic [DATA_W-1:0] p_rdata,
  input  logic              p_ready,
  input  logic              p_slverr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  // A TIMEOUT of 0 wraps the limit to all-ones, but the enable gates it off.
  localparam logic [15:0] LP_WAIT_LIMIT = 16'(TIMEOUT - 1);
  localparam bit          LP_WDOG_EN    = (TIMEOUT != 0);

  state_t              r_state;
  logic [15:0]         r_wait_cnt;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_slverr;
  logic                r_rsp_timeout;
  logic [ADDR_W-1:0]   r_p_add;
  logic                r_p_sel;
  logic                r_p_enable;
  logic                r_p_write;
  logic [DATA_W-1:0]   r_p_wdata;

  logic w_cmd_fire;
  logic w_rsp_fire;
  logic w_timeout_hit;

  assign w_cmd_fire    = cmd_valid && r_cmd_ready;
  assign w_rsp_fire    = r_rsp_valid && rsp_ready;
  assign w_timeout_hit = LP_WDOG_EN && (r_wait_cnt == LP_WAIT_LIMIT) && !p_ready;

  always_ff @(posedge p_clk or negedge p_reset) begin
    if (!p_reset) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_p_add       <= '0;
      r_p_sel       <= 1'b0;
      r_p_enable    <= 1'b0;
      r_p_write     <= 1'b0;
      r_p_wdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= !w_cmd_fire;
          if (w_cmd_fire) begin
            r_p_add    <= cmd_addr;
            r_p_write  <= cmd_write;
            r_p_wdata  <= cmd_wdata;
            r_p_sel    <= 1'b1;
            r_p_enable <= 1'b0;
            r_state    <= S_SETUP;
          end
        end

        S_SETUP: begin
          r_p_enable <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= S_ACCESS;
        end

        // Slave completion wins over the watchdog when both land on one edge.
        S_ACCESS: begin
          if (p_ready) begin
            r_rsp_rdata   <= r_p_write ? '0 : p_rdata;
            r_rsp_slverr  <= p_slverr;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_p_sel       <= 1'b0;
            r_p_enable    <= 1'b0;
            r_wait_cnt    <= '0;
            r_state       <= S_RESP;
          end else if (w_timeout_hit) begin
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_p_sel       <= 1'b0;
            r_p_enable    <= 1'b0;
            r_wait_cnt    <= '0;
            r_state       <= S_RESP;
          end else if (r_wait_cnt != 16'hFFFF) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end

        S_RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_p_sel     <= 1'b0;
          r_p_enable  <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b0;
          r_wait_cnt  <= '0;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_slverr  = r_rsp_slverr;
  assign rsp_timeout = r_rsp_timeout;
  assign p_add       = r_p_add;
  assign p_sel       = r_p_sel;
  assign p_enable    = r_p_enable;
  assign p_write     = r_p_write;
  assign p_wdata     = r_p_wdata;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: each step drives inputs on the falling edge
// and compares registered outputs against hand-computed values.
module tb_apb_master;

  logic        p_clk;
  logic        p_reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic [31:0] p_add;
  logic        p_sel;
  logic        p_enable;
  logic        p_write;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;
  logic        p_ready;
  logic        p_slverr;

  int vectors;
  int miscompares;

  apb_master #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .p_clk      (p_clk),
    .p_reset    (p_reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .p_add      (p_add),
    .p_sel      (p_sel),
    .p_enable   (p_enable),
    .p_write    (p_write),
    .p_wdata    (p_wdata),
    .p_rdata    (p_rdata),
    .p_ready    (p_ready),
    .p_slverr   (p_slverr)
  );

  initial begin
    p_clk = 1'b0;
    forever #5 p_clk = ~p_clk;
  end

  task automatic tick();
    @(negedge p_clk);
  endtask

  task automatic applyStimulus(input logic valid, input logic write,
                               input logic [31:0] addr, input logic [31:0] wdata);
    cmd_valid = valid;
    cmd_write = write;
    cmd_addr  = addr;
    cmd_wdata = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    p_reset     = 1'b1;
    rsp_ready   = 1'b0;
    p_ready     = 1'b0;
    p_slverr    = 1'b0;
    p_rdata     = 32'h0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #1 p_reset = 1'b0;

    tick();
    checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("reset p_sel", 32'(p_sel), 32'd0);
    checkOutput("reset p_enable", 32'(p_enable), 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset p_add", p_add, 32'h0);
    tick();
    p_reset = 1'b1;
    tick();
    checkOutput("cmd_ready after release", 32'(cmd_ready), 32'd1);

    $display("[TB] zero-wait write");
    p_ready = 1'b1;
    p_rdata = 32'hAAAA5555;
    applyStimulus(1'b1, 1'b1, 32'h04, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("wr setup p_sel", 32'(p_sel), 32'd1);
    checkOutput("wr setup p_enable", 32'(p_enable), 32'd0);
    checkOutput("wr setup p_add", p_add, 32'h04);
    checkOutput("wr setup p_write", 32'(p_write), 32'd1);
    checkOutput("wr setup p_wdata", p_wdata, 32'hDEADBEEF);
    checkOutput("wr setup cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    checkOutput("wr access p_sel", 32'(p_sel), 32'd1);
    checkOutput("wr access p_enable", 32'(p_enable), 32'd1);
    checkOutput("wr access rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("wr rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("wr rsp_slverr", 32'(rsp_slverr), 32'd0);
    checkOutput("wr rsp_timeout", 32'(rsp_timeout), 32'd0);
    checkOutput("wr rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("wr resp p_sel", 32'(p_sel), 32'd0);
    checkOutput("wr resp p_enable", 32'(p_enable), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("wr after hs rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("wr after hs cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("wr idle p_add held", p_add, 32'h04);

    $display("[TB] read with two wait states");
    p_ready = 1'b0;
    p_rdata = 32'hFFFF0000;
    applyStimulus(1'b1, 1'b0, 32'h08, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("rd setup p_enable", 32'(p_enable), 32'd0);
    checkOutput("rd setup p_add", p_add, 32'h08);
    checkOutput("rd setup p_write", 32'(p_write), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rd access p_enable", 32'(p_enable), 32'd1);
      checkOutput("rd access p_add", p_add, 32'h08);
      checkOutput("rd access rsp_valid", 32'(rsp_valid), 32'd0);
    end
    p_ready = 1'b1;
    p_rdata = 32'h12345678;
    tick();
    checkOutput("rd rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rd rsp_rdata", rsp_rdata, 32'h12345678);
    checkOutput("rd rsp_slverr", 32'(rsp_slverr), 32'd0);
    checkOutput("rd resp p_sel", 32'(p_sel), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("rd after hs rsp_valid", 32'(rsp_valid), 32'd0);

    $display("[TB] slave error");
    p_ready  = 1'b1;
    p_slverr = 1'b1;
    p_rdata  = 32'hCAFEF00D;
    applyStimulus(1'b1, 1'b0, 32'h0C, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("err rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("err rsp_slverr", 32'(rsp_slverr), 32'd1);
    checkOutput("err rsp_timeout", 32'(rsp_timeout), 32'd0);
    checkOutput("err rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    p_slverr  = 1'b0;

    $display("[TB] watchdog timeout");
    p_ready = 1'b0;
    p_rdata = 32'h77777777;
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("to access p_enable", 32'(p_enable), 32'd1);
      checkOutput("to access rsp_valid", 32'(rsp_valid), 32'd0);
    end
    tick();
    checkOutput("to p_sel", 32'(p_sel), 32'd0);
    checkOutput("to p_enable", 32'(p_enable), 32'd0);
    checkOutput("to rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("to rsp_slverr", 32'(rsp_slverr), 32'd1);
    checkOutput("to rsp_timeout", 32'(rsp_timeout), 32'd1);
    checkOutput("to rsp_rdata", rsp_rdata, 32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("to after hs rsp_valid", 32'(rsp_valid), 32'd0);

    $display("[TB] ready on the last allowed wait cycle");
    applyStimulus(1'b1, 1'b0, 32'h14, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("edge access p_enable", 32'(p_enable), 32'd1);
    end
    tick();
    checkOutput("edge 4th access p_enable", 32'(p_enable), 32'd1);
    p_ready = 1'b1;
    p_rdata = 32'h0BADCAFE;
    tick();
    checkOutput("edge rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("edge rsp_timeout", 32'(rsp_timeout), 32'd0);
    checkOutput("edge rsp_slverr", 32'(rsp_slverr), 32'd0);
    checkOutput("edge rsp_rdata", rsp_rdata, 32'h0BADCAFE);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    $display("[TB] backpressure and back-to-back");
    p_ready = 1'b1;
    p_rdata = 32'h11111111;
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h55AA55AA);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h24, 32'h0);
    checkOutput("bp setup cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    checkOutput("bp access p_add", p_add, 32'h20);
    checkOutput("bp access cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp held rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp held rsp_rdata", rsp_rdata, 32'h0);
      checkOutput("bp held rsp_slverr", 32'(rsp_slverr), 32'd0);
      checkOutput("bp held cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("bp held p_sel", 32'(p_sel), 32'd0);
      p_rdata = 32'h10000000 + 32'(i);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("bp after hs rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp after hs cmd_ready", 32'(cmd_ready), 32'd1);
    p_rdata = 32'h24242424;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("b2b setup p_sel", 32'(p_sel), 32'd1);
    checkOutput("b2b setup p_add", p_add, 32'h24);
    checkOutput("b2b setup p_write", 32'(p_write), 32'd0);
    checkOutput("b2b setup cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    tick();
    checkOutput("b2b rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("b2b rsp_rdata", rsp_rdata, 32'h24242424);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    $display("[TB] reset during a wait state");
    p_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("rst pre p_enable", 32'(p_enable), 32'd1);
    #2 p_reset = 1'b0;
    #1;
    checkOutput("rst async p_sel", 32'(p_sel), 32'd0);
    checkOutput("rst async p_enable", 32'(p_enable), 32'd0);
    checkOutput("rst async cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    p_ready = 1'b1;
    p_reset = 1'b1;
    tick();
    checkOutput("rst release cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst release rsp_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("rst no rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst no p_sel", 32'(p_sel), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
